// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the fetch / load-store memory port arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 4;
  localparam int DEF_TIMEOUT    = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_BUSY = 2'd1,
    ST_LS_BUSY = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Priority select between fetch and load/store with a saturating fetch-starvation counter.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   if_req,
  input  logic   ls_req,
  input  logic   if_gnt,
  input  logic   ls_gnt,
  output owner_t sel_owner,
  output logic   sel_valid
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == CW'(STARVE_MAX));

  // Load/store normally wins; fetch wins once it has been passed over STARVE_MAX times.
  always_comb begin
    sel_valid = if_req | ls_req;
    sel_owner = OWN_LS;
    if (if_req && (starved || !ls_req)) sel_owner = OWN_IF;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (if_gnt) begin
      starve_cnt <= '0;
    end else if (ls_gnt && if_req && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch, load/store) single-outstanding memory port arbiter.
// Optional ack timeout with err pulse is enabled by defining ARB_TIMEOUT_EN.
// Handshake: a requester holds req and fields until its gnt (combinational, IDLE only);
// mem_req and mem_* hold until mem_ack is sampled high; rvalid pulses the cycle after.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err,
  output state_t              dbg_state
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t state, state_nxt;
  owner_t sel_owner;
  logic   sel_valid;
  logic   timeout_hit;
  logic   done;

  mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .ls_req    (ls_req),
    .if_gnt    (if_gnt),
    .ls_gnt    (ls_gnt),
    .sel_owner (sel_owner),
    .sel_valid (sel_valid)
  );

`ifdef ARB_TIMEOUT_EN
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) to_cnt <= '0;
    else if (!mem_req || mem_ack) to_cnt <= '0;
    else to_cnt <= to_cnt + 1'b1;
  end

  assign timeout_hit = mem_req && !mem_ack && (to_cnt == TW'(TIMEOUT - 1));
`else
  logic [TW-1:0] unused_timeout_w;
  assign unused_timeout_w = '0;
  assign timeout_hit      = 1'b0;
  assign err              = 1'b0;
`endif

  // mem_req is high exactly while busy, so an ack with mem_req low never completes anything.
  assign done      = mem_req && (mem_ack || timeout_hit);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (if_gnt)      state_nxt = ST_IF_BUSY;
        else if (ls_gnt) state_nxt = ST_LS_BUSY;
      end
      ST_IF_BUSY, ST_LS_BUSY: begin
        if (done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Grants are combinational but forced low while reset is asserted.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!reset && state == ST_IDLE && sel_valid) begin
      if (sel_owner == OWN_IF) if_gnt = 1'b1;
      else                     ls_gnt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rvalid <= 1'b0;
      ls_rdata  <= '0;
`ifdef ARB_TIMEOUT_EN
      err       <= 1'b0;
`endif
    end else begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      err       <= 1'b0;
`endif
      if (if_gnt) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_be    <= '1;
      end else if (ls_gnt) begin
        mem_req   <= 1'b1;
        mem_we    <= ls_we;
        mem_addr  <= ls_addr;
        mem_wdata <= ls_wdata;
        mem_be    <= ls_be;
      end else if (done) begin
        mem_req <= 1'b0;
`ifdef ARB_TIMEOUT_EN
        err     <= timeout_hit;
`endif
        if (state == ST_IF_BUSY) begin
          if_rvalid <= 1'b1;
          if_rdata  <= timeout_hit ? '0 : mem_rdata;
        end else begin
          ls_rvalid <= 1'b1;
          ls_rdata  <= (timeout_hit || mem_we) ? '0 : mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: drivers issue requests and act as memory, a monitor
// checks every rvalid/err against an expected-response queue.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic [BW-1:0] ls_be;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          err;
  state_t        dbg_state;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  // {err, owner (1 = load/store), rdata}
  logic [DW+1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [DW+1:0] e;
    logic [DW+1:0] act;
    if (!reset) begin
      if (if_gnt || ls_gnt) check("gnt_exclusive", 64'(if_gnt & ls_gnt), 64'd0);
      if (if_rvalid || ls_rvalid || err) begin
        check("rvalid_present", 64'(if_rvalid | ls_rvalid), 64'd1);
        check("single_rvalid", 64'(if_rvalid & ls_rvalid), 64'd0);
        act = {err, ls_rvalid, ls_rvalid ? ls_rdata : if_rdata};
        if (exp_q.size() == 0) begin
          check("unexpected_response", 64'(act), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("response", 64'(act), 64'(e));
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output logic owner, output logic ok);
    ok = 1'b0;
    owner = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if_gnt || ls_gnt) begin
        ok = 1'b1;
        owner = ls_gnt;
        break;
      end
    end
    if (!ok) check("gnt_wait_expired", 64'd0, 64'd1);
  endtask

  task automatic check_mem(input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [BW-1:0] be);
    check("mem_req", 64'(mem_req), 64'd1);
    check("mem_we", 64'(mem_we), 64'(we));
    check("mem_addr", 64'(mem_addr), 64'(addr));
    check("mem_wdata", 64'(mem_wdata), 64'(wdata));
    check("mem_be", 64'(mem_be), 64'(be));
  endtask

  // Called one step into the first mem_req cycle; acks after 'delay' further cycles.
  task automatic serve(input int delay, input logic [DW-1:0] rd);
    repeat (delay) begin
      tick();
      check("mem_req_hold", 64'(mem_req), 64'd1);
    end
    mem_ack   = 1'b1;
    mem_rdata = rd;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    check("mem_req_drop", 64'(mem_req), 64'd0);
  endtask

  logic o;
  logic ok;
  logic exp_order [10];

  initial begin
    reset = 1'b1;
    if_req = 1'b1; if_addr = '0;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_be = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // reset state with requests pending
    repeat (3) tick();
    check("rst_if_gnt", 64'(if_gnt), 64'd0);
    check("rst_ls_gnt", 64'(ls_gnt), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_rvalid", 64'({if_rvalid, ls_rvalid, err}), 64'd0);
    check("rst_rdata", 64'({if_rdata, ls_rdata}), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    if_req = 1'b0; ls_req = 1'b0;
    reset = 1'b0;
    tick();

    // single fetch
    if_req = 1'b1; if_addr = 32'h0000_0010;
    wait_gnt(o, ok);
    check("fetch_owner", 64'(o), 64'd0);
    exp_q.push_back({1'b0, 1'b0, 32'h0000_0013});
    tick();
    if_req = 1'b0; if_addr = '0;
    check("fetch_gnt_one_cycle", 64'(if_gnt), 64'd0);
    check("fetch_state", 64'(dbg_state), 64'(ST_IF_BUSY));
    check_mem(1'b0, 32'h10, 32'h0, 4'hf);
    serve(2, 32'h0000_0013);
    repeat (3) tick();
    check("if_rdata_hold", 64'(if_rdata), 64'h13);

    // store: rdata must be zero regardless of mem_rdata
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h100; ls_wdata = 32'hCAFE_BABE; ls_be = 4'b0011;
    wait_gnt(o, ok);
    check("store_owner", 64'(o), 64'd1);
    exp_q.push_back({1'b0, 1'b1, 32'h0});
    tick();
    ls_req = 1'b0;
    check_mem(1'b1, 32'h100, 32'hCAFE_BABE, 4'b0011);
    serve(1, 32'hDEAD_BEEF);

    // load with immediate ack
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200; ls_wdata = '0; ls_be = 4'hf;
    wait_gnt(o, ok);
    check("load_owner", 64'(o), 64'd1);
    exp_q.push_back({1'b0, 1'b1, 32'h0000_55AA});
    tick();
    ls_req = 1'b0;
    check_mem(1'b0, 32'h200, 32'h0, 4'hf);
    serve(0, 32'h0000_55AA);
    repeat (2) tick();
    check("ls_rdata_hold", 64'(ls_rdata), 64'h55AA);
    check("if_rdata_untouched", 64'(if_rdata), 64'h13);

    // contention: fetch starved for four load/store grants, then served
    if_req = 1'b1; if_addr = 32'h40;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h300; ls_be = 4'hf;
    for (int i = 0; i < 10; i++) begin
      wait_gnt(o, ok);
      check($sformatf("contention_order_%0d", i), 64'(o), 64'(exp_order[i]));
      exp_q.push_back({1'b0, exp_order[i], 32'h1000 + 32'(i)});
      tick();
      check("contention_addr", 64'(mem_addr), exp_order[i] ? 64'h300 : 64'h40);
      serve(1, 32'h1000 + 32'(i));
    end
    if_req = 1'b0; ls_req = 1'b0;
    tick();

    // reset mid-transaction, then a late ack
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h400;
    wait_gnt(o, ok);
    tick();
    ls_req = 1'b0;
    check("pre_reset_mem_req", 64'(mem_req), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async_mem_req", 64'(mem_req), 64'd0);
    check("async_mem_addr", 64'(mem_addr), 64'd0);
    check("async_state", 64'(dbg_state), 64'(ST_IDLE));
    check("async_rdata", 64'({if_rdata, ls_rdata}), 64'd0);
    tick();
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h77;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) tick();
    check("late_ack_mem_req", 64'(mem_req), 64'd0);
    check("late_ack_state", 64'(dbg_state), 64'(ST_IDLE));

    // stray ack in IDLE
    mem_ack = 1'b1; mem_rdata = 32'h99;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    tick();
    check("stray_state", 64'(dbg_state), 64'(ST_IDLE));
    check("stray_mem_req", 64'(mem_req), 64'd0);
    check("stray_ls_rdata", 64'(ls_rdata), 64'd0);

    // no ack: timeout abort, or indefinite wait without the timeout build
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h500; ls_be = 4'hf;
    wait_gnt(o, ok);
`ifdef ARB_TIMEOUT_EN
    exp_q.push_back({1'b1, 1'b1, 32'h0});
`else
    exp_q.push_back({1'b0, 1'b1, 32'h0000_0005});
`endif
    tick();
    ls_req = 1'b0;
    mem_rdata = 32'hABCD;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      check("timeout_hold", 64'(mem_req), 64'd1);
      tick();
    end
    check("timeout_drop", 64'(mem_req), 64'd0);
    check("timeout_state", 64'(dbg_state), 64'(ST_IDLE));
    tick();
    check("timeout_err_pulse", 64'(err), 64'd0);
`else
    repeat (40) tick();
    check("no_timeout_mem_req", 64'(mem_req), 64'd1);
    check("no_timeout_err", 64'(err), 64'd0);
    serve(0, 32'h0000_0005);
`endif
    mem_rdata = '0;

    // drain and report
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
